sm_addsub_pipe: RTL and testbench
=================================

# sm_addsub_pipe

Pipelined, multi-lane sign-magnitude fixed-point add/subtract unit for the SVM datapath. Each cycle it accepts one vector of `LANES` operand pairs and returns `LANES` results two cycles later. It adds a per-lane add/sub mode, overflow detection with optional saturation, and negative-zero normalisation, all behind a valid/ready handshake. It sits between the feature/support-vector fetch and the kernel multiply-accumulate stage.

## Interface
Parameters:
- `XLEN_PIXEL`, 8: half word width. Word `W = 2*XLEN_PIXEL` bits: MSB is the sign, the low `W-1` bits are the magnitude.
- `LANES`, 4: number of independent lanes processed per beat.

Ports:
- `clk`  in  1  : single clock; every register updates on the rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `in_valid`  in  1  : input beat valid.
- `in_ready`  out  1  : unit can accept a beat.
- `in_a`  in  LANES*W  : operand A; lane i is bits `[i*W +: W]`.
- `in_b`  in  LANES*W  : operand B, same packing.
- `in_op`  in  LANES  : per-lane mode. 0 = A−B, 1 = A+B.
- `out_valid`  out  1  : result beat valid.
- `out_ready`  in  1  : downstream accepts the beat.
- `out_res`  out  LANES*W  : sign-magnitude results, same packing.
- `out_ovf`  out  LANES  : per-lane overflow flag, aligned with `out_res`.

## Operation
- A beat transfers when `in_valid && in_ready`. The output transfers when `out_valid && out_ready`.
- Stage 1 (register S1), per lane:
  - Compute the effective B sign: `eb = b_sign ^ ~op`.
  - If `a_sign == eb`, mark the lane as a magnitude add.
  - Otherwise mark it as a magnitude subtract. Register which operand is larger (`a_mag > b_mag`, `a_mag == b_mag`) together with both magnitudes and signs.
- Stage 2 (register S2 = output), per lane:
  - Add: `sum = a_mag + b_mag`, computed `W` bits wide. Result sign = `a_sign`. `ovf = sum[W-1]`.
  - Subtract: magnitude = larger − smaller. Sign = sign of the larger operand (`a_sign` or `eb`). `ovf = 0`.
  - Zero normalisation: a magnitude of 0 always yields sign 0, regardless of operand signs. Inputs 0x8000 and 0x0000 are therefore both treated as zero.
  - Overflow result: see Configuration.
- Lanes are fully independent. `in_op` is sampled per lane at acceptance.
- Reset mid-operation: all in-flight beats are discarded with no partial output. The first beat accepted after reset is processed normally.

## Timing
- Reset values:
  - `out_valid = 0`, `out_res = 0`, `out_ovf = 0`.
  - Internal S1 valid = 0.
  - `in_ready = 1` in the cycle after `rst` deasserts.
- Latency: 2 cycles from the input handshake edge to `out_valid` high, provided `out_ready` stays high.
- Throughput: 1 beat per cycle with no bubbles while `out_ready = 1`.
- Stage advance rules:
  - S2 loads when `!out_valid || out_ready`.
  - S1 loads when `!s1_valid || s2_load`.
  - `in_ready = !s1_valid || s2_load`. It is combinational from `out_ready`, with no combinational path from `in_valid`.
- Stall: while `out_valid && !out_ready`, `out_res` and `out_ovf` hold stable. At most 2 beats are buffered (S1 + S2), after which `in_ready = 0`.
- Simultaneous output pop and input push in the same cycle: both occur and nothing is lost or duplicated.
- `in_a`, `in_b` and `in_op` are ignored when `in_valid = 0`.

## Configuration
- Macro `SM_ADDSUB_SAT_EN`:
  - Defined: an overflowing lane outputs the saturated magnitude `{sign, {W-1{1'b1}}}`. With `W = 16` this is 0x7FFF or 0xFFFF.
  - Undefined: an overflowing lane outputs the wrapped magnitude `sum[W-2:0]` with the computed sign, then zero normalisation is applied.
  - `out_ovf` is generated identically in both builds.

## Structure
- Shared package `sm_arith_pkg`:
  - word width function `W(XLEN_PIXEL)`;
  - `OP_SUB = 1'b0`, `OP_ADD = 1'b1`;
  - sign-bit and magnitude field index constants.
- Sub-module `sm_addsub_lane`: one lane's S1/S2 datapath, with data registers enabled by the shared load strobes. Instantiated `LANES` times in a generate loop.
- The top level owns the valid/ready control and the S1/S2 valid bits.

## Test plan
Configuration: `XLEN_PIXEL = 8`, `LANES = 4`, `out_ready = 1` unless noted.
- Basic subtract: A=0x0005, B=0x0003, op=0 → 0x0002, ovf 0. A=0x0003, B=0x0005 → 0x8002. A=0x8003 (−3), B=0x8005 (−5) → 0x0002. `out_valid` rises exactly 2 cycles after the handshake.
- Mixed signs and add mode:
  - A=0x8004, B=0x0004, op=0 → 0x8008.
  - A=0x8004, B=0x0004, op=1 → 0x0000 (no negative zero).
  - A=0x8000, B=0x0000, op=1 → 0x0000.
- Overflow: A=0x7FFF, B=0x0001, op=1 → ovf 1. With `SM_ADDSUB_SAT_EN` defined the result is 0x7FFF; without it, 0x0000. A=0xFFFF, B=0x0001, op=0 → 0xFFFF (sat) or 0x0000 (wrap), ovf 1.
- Back-pressure: stream 5 beats with `out_ready = 0` for cycles 2–5.
  - Exactly 2 beats are accepted, then `in_ready = 0`.
  - `out_res` holds beat 0 stable throughout the stall.
  - After release, all 5 beats emerge in order with no gaps.
- Lane independence: 4 lanes with op = {1,0,1,0} and distinct operands in one beat. Every lane matches the scoreboard model, and the overflow flag is set only on the lane forced to overflow.
- Reset mid-flight: assert `rst` for 1 cycle while 2 beats are in flight.
  - `out_valid = 0` and `out_res = 0` next cycle; neither beat ever appears.
  - A new beat accepted after reset produces a correct result at latency 2.

Source files
------------

// File: rtl/sm_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_arith_pkg
// Description : Shared definitions for the sign-magnitude arithmetic blocks:
//               word-width helper, add/sub mode encodings and the
//               sign/magnitude field index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_arith_pkg;

    // Full word width for a given half-word (pixel) width.
    function automatic int word_w(input int xlen_pixel);
        return 2 * xlen_pixel;
    endfunction

    // Per-lane mode encodings carried on in_op.
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Field positions inside a sign-magnitude word of width w.
    function automatic int sign_idx(input int w);
        return w - 1;
    endfunction

    function automatic int mag_msb(input int w);
        return w - 2;
    endfunction

    localparam int MAG_LSB = 0;

endpackage : sm_arith_pkg
`default_nettype wire

// File: rtl/sm_addsub_lane.sv
`default_nettype none
// ============================================================================
// Module      : sm_addsub_lane
// Description : One lane of the sign-magnitude add/sub pipeline. Stage 1
//               classifies the operation (magnitude add vs. subtract) and
//               compares magnitudes; stage 2 forms the result, overflow flag
//               and normalises negative zero.
// Revision    : 1.0 - initial release
// Config      : SM_ADDSUB_SAT_EN - saturate overflowing lanes instead of
//               wrapping the magnitude.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               s1_load_i     - load stage-1 registers (accepted beat)
//               s2_load_i     - load stage-2/output registers
//               a_i, b_i      - sign-magnitude operands
//               op_i          - 0 = A-B, 1 = A+B
//               res_o, ovf_o  - registered result and overflow flag
// ============================================================================
module sm_addsub_lane
    import sm_arith_pkg::*;
#(
    parameter  int XLEN_PIXEL = 8,
    localparam int W          = word_w(XLEN_PIXEL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s1_load_i,
    input  logic         s2_load_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         op_i,
    output logic [W-1:0] res_o,
    output logic         ovf_o
);

    localparam int SB = sign_idx(W);
    localparam int MM = mag_msb(W);

    // ------------------------------------------------------------------
    // Stage 1: classify
    // ------------------------------------------------------------------
    logic         w_eb;
    logic         w_is_add;
    logic [W-2:0] w_a_mag;
    logic [W-2:0] w_b_mag;

    // Subtraction is folded into an inverted B sign, so both modes become
    // "A plus signed B".
    assign w_eb     = b_i[SB] ^ ~op_i;
    assign w_is_add = (a_i[SB] == w_eb);
    assign w_a_mag  = a_i[MM:MAG_LSB];
    assign w_b_mag  = b_i[MM:MAG_LSB];

    logic         a_sign_q;
    logic         eb_q;
    logic         is_add_q;
    logic         a_gt_q;
    logic         a_eq_q;
    logic [W-2:0] a_mag_q;
    logic [W-2:0] b_mag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sign_q <= 1'b0;
            eb_q     <= 1'b0;
            is_add_q <= 1'b0;
            a_gt_q   <= 1'b0;
            a_eq_q   <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
        end else if (s1_load_i) begin
            a_sign_q <= a_i[SB];
            eb_q     <= w_eb;
            is_add_q <= w_is_add;
            a_gt_q   <= (w_a_mag > w_b_mag);
            a_eq_q   <= (w_a_mag == w_b_mag);
            a_mag_q  <= w_a_mag;
            b_mag_q  <= w_b_mag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: compute result
    // ------------------------------------------------------------------
    logic [W-1:0] w_sum;
    logic [W-2:0] w_diff;

    // One extra bit on the sum: its MSB is the overflow indicator.
    assign w_sum  = {1'b0, a_mag_q} + {1'b0, b_mag_q};
    assign w_diff = a_gt_q ? (a_mag_q - b_mag_q) : (b_mag_q - a_mag_q);

    logic [W-2:0] mag_d;
    logic         sign_raw;
    logic         ovf_d;
    logic [W-1:0] res_d;

    always_comb begin
        mag_d    = '0;
        sign_raw = 1'b0;
        ovf_d    = 1'b0;
        if (is_add_q) begin
            ovf_d    = w_sum[W-1];
            sign_raw = a_sign_q;
`ifdef SM_ADDSUB_SAT_EN
            mag_d    = w_sum[W-1] ? {(W-1){1'b1}} : w_sum[W-2:0];
`else
            mag_d    = w_sum[W-2:0];
`endif
        end else begin
            mag_d    = w_diff;
            // Equal magnitudes give zero; the sign is cleared below anyway.
            sign_raw = a_gt_q ? a_sign_q : (a_eq_q ? 1'b0 : eb_q);
        end
        // A zero magnitude is always reported as +0.
        res_d = {sign_raw & (|mag_d), mag_d};
    end

    logic [W-1:0] res_q;
    logic         ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (s2_load_i) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_q;

endmodule : sm_addsub_lane
`default_nettype wire

// File: rtl/sm_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sm_addsub_pipe
// Description : Two-stage, multi-lane sign-magnitude add/subtract unit with a
//               valid/ready handshake on both sides. Holds up to two beats
//               (stage 1 + output stage) under back-pressure.
// Revision    : 1.0 - initial release
// Config      : SM_ADDSUB_SAT_EN - saturate overflowing lanes (else wrap).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               in_a, in_b          - LANES packed operands, lane i at [i*W +: W]
//               in_op               - per-lane mode, 0 = A-B, 1 = A+B
//               out_valid/out_ready - output handshake
//               out_res, out_ovf    - packed results and per-lane overflow
// ============================================================================
module sm_addsub_pipe
    import sm_arith_pkg::*;
#(
    parameter  int XLEN_PIXEL = 8,
    parameter  int LANES      = 4,
    localparam int W          = word_w(XLEN_PIXEL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic [LANES-1:0]   in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_res,
    output logic [LANES-1:0]   out_ovf
);

    logic s1_valid_q;
    logic s1_valid_d;
    logic out_valid_q;
    logic out_valid_d;

    logic w_s2_load;
    logic w_s1_load;
    logic w_accept;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s2_load = ~out_valid_q | out_ready;
    assign w_s1_load = ~s1_valid_q | w_s2_load;
    assign w_accept  = in_valid & w_s1_load;
    assign in_ready  = w_s1_load;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (w_s1_load) begin
            s1_valid_d = in_valid;
        end
        if (w_s2_load) begin
            out_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    // Data registers only move on real beats, so idle inputs are ignored and
    // the output word stays put when no new beat arrives.
    logic w_lane_s2_load;
    assign w_lane_s2_load = w_s2_load & s1_valid_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            sm_addsub_lane #(
                .XLEN_PIXEL (XLEN_PIXEL)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .s1_load_i (w_accept),
                .s2_load_i (w_lane_s2_load),
                .a_i       (in_a[gi*W +: W]),
                .b_i       (in_b[gi*W +: W]),
                .op_i      (in_op[gi]),
                .res_o     (out_res[gi*W +: W]),
                .ovf_o     (out_ovf[gi])
            );
        end
    endgenerate

endmodule : sm_addsub_pipe
`default_nettype wire

// File: tb/tb_sm_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_addsub_pipe
// Description : Self-checking bench for sm_addsub_pipe. Expected results come
//               from a signed-integer model of sign-magnitude arithmetic plus
//               hand-computed literals for the directed vectors.
// Revision    : 1.0 - initial release
// Config      : SM_ADDSUB_SAT_EN selects saturating expectations.
// ============================================================================
module tb_sm_addsub_pipe;

    localparam int XP = 8;
    localparam int L  = 4;
    localparam int W  = 2 * XP;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [L*W-1:0]   in_a;
    logic [L*W-1:0]   in_b;
    logic [L-1:0]     in_op;
    logic             out_valid;
    logic             out_ready;
    logic [L*W-1:0]   out_res;
    logic [L-1:0]     out_ovf;

    sm_addsub_pipe #(
        .XLEN_PIXEL (XP),
        .LANES      (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L*W-1:0] res;
        logic [L-1:0]   ovf;
        bit             lit_en;
        logic [L*W-1:0] lres;
        logic [L-1:0]   lovf;
        bit             lat;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed-integer view: value = +/-magnitude, then re-encode.
    function automatic logic [W:0] model_lane(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic op);
        int   av;
        int   bv;
        int   r;
        int   m;
        int   mag;
        logic neg;
        logic ovf;
        av = int'(a[W-2:0]);
        if (a[W-1]) av = -av;
        bv = int'(b[W-2:0]);
        if (b[W-1]) bv = -bv;
        r   = op ? (av + bv) : (av - bv);
        neg = (r < 0);
        m   = neg ? -r : r;
        ovf = (m >= (1 << (W-1)));
`ifdef SM_ADDSUB_SAT_EN
        mag = ovf ? ((1 << (W-1)) - 1) : m;
`else
        mag = m % (1 << (W-1));
`endif
        return {ovf, neg && (mag != 0), mag[W-2:0]};
    endfunction

    function automatic logic [L*W+L-1:0] model_beat(input logic [L*W-1:0] a,
                                                    input logic [L*W-1:0] b,
                                                    input logic [L-1:0] op);
        logic [L*W-1:0] r;
        logic [L-1:0]   o;
        logic [W:0]     t;
        for (int i = 0; i < L; i++) begin
            t          = model_lane(a[i*W +: W], b[i*W +: W], op[i]);
            r[i*W +: W] = t[W-1:0];
            o[i]       = t[W];
        end
        return {o, r};
    endfunction

    // Offer one beat, wait (bounded) for acceptance, record the expectation.
    task automatic send_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                             input logic [L-1:0] op, input bit lit_en,
                             input logic [L*W-1:0] lres, input logic [L-1:0] lovf,
                             input bit lat);
        bit   got    = 0;
        int   waited = 0;
        exp_t e;
        logic [L*W+L-1:0] m;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        while (!got && waited <= 100) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else waited++;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        m        = model_beat(a, b, op);
        e.res    = m[L*W-1:0];
        e.ovf    = m[L*W +: L];
        e.lit_en = lit_en;
        e.lres   = lres;
        e.lovf   = lovf;
        e.lat    = lat;
        e.cyc    = cyc;
        q.push_back(e);
        n_acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output checker: every transferred beat is compared with the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got res 0x%0h, expected no output", out_res);
                end else begin
                    e = q.pop_front();
                    chk("model_res", out_res, e.res);
                    chk("model_ovf", out_ovf, e.ovf);
                    if (e.lit_en) begin
                        chk("literal_res", out_res, e.lres);
                        chk("literal_ovf", out_ovf, e.lovf);
                    end
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed vectors, lanes packed {lane3, lane2, lane1, lane0}.
    localparam logic [L*W-1:0] A_A = {16'h8004, 16'h8003, 16'h0003, 16'h0005};
    localparam logic [L*W-1:0] A_B = {16'h0004, 16'h8005, 16'h0005, 16'h0003};
    localparam logic [L*W-1:0] A_R = {16'h8008, 16'h0002, 16'h8002, 16'h0002};
    localparam logic [L*W-1:0] B_A = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h8004};
    localparam logic [L*W-1:0] B_B = {16'h0001, 16'h0001, 16'h0000, 16'h0004};
    localparam logic [L*W-1:0] C_A = {16'h8100, 16'h0010, 16'h7000, 16'h1234};
    localparam logic [L*W-1:0] C_B = {16'h0050, 16'h8020, 16'h1000, 16'h0234};
`ifdef SM_ADDSUB_SAT_EN
    localparam logic [L*W-1:0] B_R = {16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000};
    localparam logic [L*W-1:0] C_R = {16'h80B0, 16'h0030, 16'h7FFF, 16'h1000};
`else
    localparam logic [L*W-1:0] B_R = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    localparam logic [L*W-1:0] C_R = {16'h80B0, 16'h0030, 16'h0000, 16'h1000};
`endif

    logic [L*W-1:0] bp_a [5];
    logic [L*W-1:0] bp_b [5];
    logic [L-1:0]   bp_op[5];
    logic [L*W-1:0] exp0;
    logic [L*W+L-1:0] mtmp;
    int  acc0;
    bit  drv_done;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_res", out_res, 0);
        chk("reset_out_ovf", out_ovf, 0);
        chk("reset_in_ready", in_ready, 1);

        // Directed beats, back to back at full throughput.
        @(posedge clk);
        #1;
        send_beat(A_A, A_B, 4'b0000, 1, A_R, 4'b0000, 1);
        send_beat(B_A, B_B, 4'b0111, 1, B_R, 4'b1100, 1);
        send_beat(C_A, C_B, 4'b1010, 1, C_R, 4'b0010, 1);
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: five beats against a stalled output.
        for (int i = 0; i < 5; i++) begin
            bp_a[i]  = {$urandom, $urandom};
            bp_b[i]  = {$urandom, $urandom};
            bp_op[i] = 4'($urandom);
        end
        mtmp      = model_beat(bp_a[0], bp_b[0], bp_op[0]);
        exp0      = mtmp[L*W-1:0];
        acc0      = n_acc;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_beat(bp_a[i], bp_b[i], bp_op[i], 0, '0, '0, 0);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k >= 2) begin
                        chk("stall_valid", out_valid, 1);
                        chk("stall_hold", out_res, exp0);
                    end
                end
                chk("stall_accepts", n_acc - acc0, 2);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("drain_no_gap", out_valid, 1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats buffered: neither may ever transfer.
        out_ready = 1'b0;
        send_beat(A_A, A_B, 4'b0000, 0, '0, '0, 0);
        send_beat(C_A, C_B, 4'b1010, 0, '0, '0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_res", out_res, 0);
        chk("midreset_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        send_beat(B_A, B_B, 4'b0111, 1, B_R, 4'b1100, 1);
        repeat (4) @(posedge clk);
        #1;

        // Random traffic with random back-pressure.
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 0, '0, '0, 0);
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sm_addsub_pipe
`default_nettype wire
